// File: rtl/ceyloniac_pkg.sv
// ceyloniac_pkg: shared RAM FSM encodings, default widths and the byte-merge helper
package ceyloniac_pkg;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_RUN   = 1'b1
    } ram_state_t;

    localparam int RAM_DEF_DATA_WIDTH = 32;
    localparam int RAM_DEF_ADDR_WIDTH = 16;
    localparam int RAM_DEF_BYTE_WIDTH = 8;
    localparam int RAM_MERGE_WIDTH    = 256;

    // Merges new_word into old_word byte by byte; callers zero-extend into the fixed merge width.
    function automatic logic [RAM_MERGE_WIDTH-1:0] byte_merge(
        input logic [RAM_MERGE_WIDTH-1:0] old_word,
        input logic [RAM_MERGE_WIDTH-1:0] new_word,
        input logic [RAM_MERGE_WIDTH-1:0] strobes,
        input int                         byte_width
    );
        logic [RAM_MERGE_WIDTH-1:0] merged;
        for (int i = 0; i < RAM_MERGE_WIDTH; i++)
            merged[i] = strobes[8'(i / byte_width)] ? new_word[i] : old_word[i];
        return merged;
    endfunction

endpackage

// File: rtl/ceyloniac_ram_out_stage.sv
// ceyloniac_ram_out_stage: optional output register holding read data and its valid pulse
module ceyloniac_ram_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Delay valid by one cycle; data only moves on a valid so it holds between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= load_valid;
            if (load_valid)
                data <= load_data;
        end
    end

endmodule

// File: rtl/ceyloniac_dp_sync_ram.sv
// ceyloniac_dp_sync_ram: dual-port sync RAM, A read/write with byte strobes, B read-only,
// self-clearing after reset; define CEYLONIAC_RAM_OUT_REG_EN for an extra output register.
module ceyloniac_dp_sync_ram
    import ceyloniac_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = RAM_DEF_DATA_WIDTH,
    parameter int RAM_ADDR_WIDTH = RAM_DEF_ADDR_WIDTH,
    parameter int BYTE_WIDTH     = RAM_DEF_BYTE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 ram_init_busy,
    input  logic                                 a_enable,
    input  logic                                 a_write_enable,
    input  logic [RAM_DATA_WIDTH/BYTE_WIDTH-1:0] a_byte_enable,
    input  logic [RAM_ADDR_WIDTH-1:0]            a_addr,
    input  logic [RAM_DATA_WIDTH-1:0]            a_write_data,
    output logic [RAM_DATA_WIDTH-1:0]            a_read_data,
    output logic                                 a_read_valid,
    input  logic                                 b_enable,
    input  logic [RAM_ADDR_WIDTH-1:0]            b_addr,
    output logic [RAM_DATA_WIDTH-1:0]            b_read_data,
    output logic                                 b_read_valid
);

    localparam int NUM_BYTES = RAM_DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 1 << RAM_ADDR_WIDTH;

    ram_state_t                state, state_next;
    logic [RAM_ADDR_WIDTH-1:0] clear_cnt;
    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];
    logic [RAM_DATA_WIDTH-1:0] a_old, b_old, a_merged;
    logic [RAM_DATA_WIDTH-1:0] a_data_q, b_data_q;
    logic                      a_valid_q, b_valid_q;
    logic                      run, a_fire, a_wr, b_fire, collide;
    logic [NUM_BYTES-1:0]      strobes;

    assign run           = (state == RAM_ST_RUN);
    assign ram_init_busy = ~run;
    assign a_fire        = run & a_enable;
    assign a_wr          = a_fire & a_write_enable;
    assign b_fire        = run & b_enable;
    assign collide       = a_wr & (a_addr == b_addr);
    assign strobes       = a_byte_enable;
    assign a_old         = mem[a_addr];
    assign b_old         = mem[b_addr];
    assign a_merged      = RAM_DATA_WIDTH'(byte_merge(RAM_MERGE_WIDTH'(a_old),
                                                      RAM_MERGE_WIDTH'(a_write_data),
                                                      RAM_MERGE_WIDTH'(strobes),
                                                      BYTE_WIDTH));

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RAM_ST_CLEAR;
        else
            state <= state_next;
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next = state;
        if (state == RAM_ST_CLEAR && clear_cnt == '1)
            state_next = RAM_ST_RUN;
    end

    // Clear sweep address, advancing one word per cycle while clearing.
    always_ff @(posedge clk) begin
        if (rst)
            clear_cnt <= '0;
        else if (!run)
            clear_cnt <= clear_cnt + 1'b1;
    end

    // Storage array: zero fill during CLEAR, byte-merged port A writes during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run)
                mem[clear_cnt] <= '0;
            else if (a_wr)
                mem[a_addr] <= a_merged;
        end
    end

    // Registered reads; writes return the merged word and B sees it on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= a_fire;
            b_valid_q <= b_fire;
            if (a_fire)
                a_data_q <= a_write_enable ? a_merged : a_old;
            if (b_fire)
                b_data_q <= collide ? a_merged : b_old;
        end
    end

`ifdef CEYLONIAC_RAM_OUT_REG_EN
    ceyloniac_ram_out_stage #(.WIDTH(RAM_DATA_WIDTH)) u_a_out (
        .clk       (clk),
        .rst       (rst),
        .load_data (a_data_q),
        .load_valid(a_valid_q),
        .data      (a_read_data),
        .valid     (a_read_valid)
    );
    ceyloniac_ram_out_stage #(.WIDTH(RAM_DATA_WIDTH)) u_b_out (
        .clk       (clk),
        .rst       (rst),
        .load_data (b_data_q),
        .load_valid(b_valid_q),
        .data      (b_read_data),
        .valid     (b_read_valid)
    );
`else
    assign a_read_data  = a_data_q;
    assign a_read_valid = a_valid_q;
    assign b_read_data  = b_data_q;
    assign b_read_valid = b_valid_q;
`endif

endmodule

// File: tb/tb_ceyloniac_dp_sync_ram.sv
// tb_ceyloniac_dp_sync_ram: directed self-checking bench for the dual-port RAM (16 words)
module tb_ceyloniac_dp_sync_ram;

    localparam int DW = 32;
    localparam int AW = 4;
`ifdef CEYLONIAC_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ram_init_busy;
    logic          a_enable, a_write_enable, b_enable;
    logic [3:0]    a_byte_enable;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_write_data, a_read_data, b_read_data;
    logic          a_read_valid, b_read_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ceyloniac_dp_sync_ram #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .BYTE_WIDTH    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ram_init_busy (ram_init_busy),
        .a_enable      (a_enable),
        .a_write_enable(a_write_enable),
        .a_byte_enable (a_byte_enable),
        .a_addr        (a_addr),
        .a_write_data  (a_write_data),
        .a_read_data   (a_read_data),
        .a_read_valid  (a_read_valid),
        .b_enable      (b_enable),
        .b_addr        (b_addr),
        .b_read_data   (b_read_data),
        .b_read_valid  (b_read_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_enable       = 1'b0;
        a_write_enable = 1'b0;
        a_byte_enable  = 4'h0;
        a_addr         = '0;
        a_write_data   = '0;
        b_enable       = 1'b0;
        b_addr         = '0;
    endtask

    task automatic drive(input logic ae, input logic we, input logic [3:0] be, input logic [AW-1:0] aa,
                         input logic [DW-1:0] wd, input logic bb, input logic [AW-1:0] ba);
        a_enable       = ae;
        a_write_enable = we;
        a_byte_enable  = be;
        a_addr         = aa;
        a_write_data   = wd;
        b_enable       = bb;
        b_addr         = ba;
    endtask

    task automatic access(input logic ae, input logic we, input logic [3:0] be, input logic [AW-1:0] aa,
                          input logic [DW-1:0] wd, input logic bb, input logic [AW-1:0] ba);
        drive(ae, we, be, aa, wd, bb, ba);
        tick;
        idle;
        repeat (LAT - 1) tick;
    endtask

    task automatic count_busy(output int n, output int stray);
        n     = 0;
        stray = 0;
        while (ram_init_busy === 1'b1 && n < 100) begin
            n++;
            drive(1'b1, 1'b0, 4'h0, AW'(n), '0, 1'b1, AW'(n));
            tick;
            if (a_read_valid !== 1'b0 || b_read_valid !== 1'b0) stray++;
        end
        idle;
        repeat (LAT) tick;
    endtask

    task automatic test_reset;
        int n, stray;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({ram_init_busy, a_read_valid, b_read_valid, a_read_data, b_read_data} !== {3'b100, 64'h0}) begin
            failures++;
            $display("FAIL reset_outputs busy=%b av=%b bv=%b ad=%h bd=%h want busy=1 rest 0",
                     ram_init_busy, a_read_valid, b_read_valid, a_read_data, b_read_data);
        end
        count_busy(n, stray);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL reset_busy_len got=%0d want=16", n);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_busy_valid got=%0d stray valids want=0", stray);
        end
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b1, AW'(15 - i));
            checks++;
            if ({a_read_valid, b_read_valid, a_read_data, b_read_data} !== {2'b11, 64'h0}) begin
                failures++;
                $display("FAIL clear_read[%0d] av=%b bv=%b ad=%h bd=%h want 1 1 0 0",
                         i, a_read_valid, b_read_valid, a_read_data, b_read_data);
            end
        end
    endtask

    task automatic test_full_write;
        access(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, '0);
        checks++;
        if (a_read_valid !== 1'b1 || a_read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_write_return v=%b d=%h want 1 deadbeef", a_read_valid, a_read_data);
        end
        drive(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b0, '0);
        tick;
        idle;
        checks++;
        if (a_read_valid !== (LAT == 1)) begin
            failures++;
            $display("FAIL latency_first_edge v=%b want %b", a_read_valid, LAT == 1);
        end
        if (LAT == 2) tick;
        checks++;
        if (a_read_valid !== 1'b1 || a_read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_write_read v=%b d=%h want 1 deadbeef", a_read_valid, a_read_data);
        end
        tick;
        checks++;
        if (a_read_valid !== 1'b0 || a_read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL valid_pulse_hold v=%b d=%h want 0 deadbeef", a_read_valid, a_read_data);
        end
    endtask

    task automatic test_byte_write;
        access(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0);
        checks++;
        if (a_read_data !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL byte_write_return got=%h want=de22be44", a_read_data);
        end
        access(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b1, 4'd3);
        checks++;
        if (a_read_data !== 32'hDE22BE44 || b_read_data !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL byte_write_read a=%h b=%h want=de22be44", a_read_data, b_read_data);
        end
        access(1'b1, 1'b1, 4'h0, 4'd3, 32'hFFFFFFFF, 1'b0, '0);
        checks++;
        if (a_read_valid !== 1'b1 || a_read_data !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL zero_strobe_return v=%b d=%h want 1 de22be44", a_read_valid, a_read_data);
        end
        access(1'b0, 1'b1, 4'hF, 4'd3, 32'h0BADF00D, 1'b0, '0);
        checks++;
        if (a_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL disabled_write_valid got=%b want=0", a_read_valid);
        end
        access(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b0, '0);
        checks++;
        if (a_read_data !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL no_write_read got=%h want=de22be44", a_read_data);
        end
    endtask

    task automatic test_collision;
        access(1'b1, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D, 1'b1, 4'd5);
        checks++;
        if (b_read_valid !== 1'b1 || b_read_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL collision_full v=%b d=%h want 1 cafef00d", b_read_valid, b_read_data);
        end
        access(1'b1, 1'b1, 4'b1000, 4'd5, 32'h77000000, 1'b1, 4'd5);
        checks++;
        if (b_read_data !== 32'h77FEF00D || a_read_data !== 32'h77FEF00D) begin
            failures++;
            $display("FAIL collision_partial a=%h b=%h want=77fef00d", a_read_data, b_read_data);
        end
        access(1'b1, 1'b1, 4'hF, 4'd6, 32'h12121212, 1'b1, 4'd5);
        checks++;
        if (b_read_data !== 32'h77FEF00D) begin
            failures++;
            $display("FAIL no_collision_diff_addr got=%h want=77fef00d", b_read_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d;
        for (int c = 0; c < 4 + LAT - 1; c++) begin
            if (c < 4) drive(1'b1, 1'b1, 4'hF, AW'(8 + c), 32'hA0000000 + DW'(c), 1'b1, AW'(8 + c));
            else idle;
            tick;
            if (c >= LAT - 1) begin
                d = 32'hA0000000 + DW'(c - LAT + 1);
                checks++;
                if ({a_read_valid, b_read_valid, a_read_data, b_read_data} !== {2'b11, d, d}) begin
                    failures++;
                    $display("FAIL b2b_write[%0d] av=%b bv=%b a=%h b=%h want %h", c, a_read_valid,
                             b_read_valid, a_read_data, b_read_data, d);
                end
            end
        end
        idle;
        for (int c = 0; c < 4 + LAT - 1; c++) begin
            if (c < 4) drive(1'b1, 1'b0, 4'h0, AW'(11 - c), '0, 1'b1, AW'(8 + c));
            else idle;
            tick;
            if (c >= LAT - 1) begin
                checks++;
                if (a_read_data !== 32'hA0000000 + DW'(3 - (c - LAT + 1)) ||
                    b_read_data !== 32'hA0000000 + DW'(c - LAT + 1) || a_read_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_read[%0d] av=%b a=%h b=%h", c, a_read_valid, a_read_data, b_read_data);
                end
            end
        end
        idle;
        tick;
    endtask

    task automatic test_reset_mid_run;
        int n, stray;
        drive(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b1, 4'd5);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({a_read_valid, b_read_valid, a_read_data, b_read_data, ram_init_busy} !== {66'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_run av=%b bv=%b a=%h b=%h busy=%b want all 0 busy 1",
                     a_read_valid, b_read_valid, a_read_data, b_read_data, ram_init_busy);
        end
        count_busy(n, stray);
        checks++;
        if (n != 16 || stray != 0) begin
            failures++;
            $display("FAIL reset_mid_run_busy len=%0d stray=%0d want 16 0", n, stray);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n, stray;
        access(1'b1, 1'b1, 4'hF, 4'd3, 32'h55AA55AA, 1'b0, '0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFFFFFF, 1'b1, 4'd3);
            tick;
            if (a_read_valid !== 1'b0 || b_read_valid !== 1'b0) stray++;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        count_busy(n, stray);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL reset_mid_clear_busy got=%0d want=16", n);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL busy_no_valid got=%0d stray want=0", stray);
        end
        access(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b1, 4'd5);
        checks++;
        if ({a_read_valid, b_read_valid, a_read_data, b_read_data} !== {2'b11, 64'h0}) begin
            failures++;
            $display("FAIL recleared av=%b bv=%b a=%h b=%h want 1 1 0 0",
                     a_read_valid, b_read_valid, a_read_data, b_read_data);
        end
    endtask

    initial begin
        idle;
        test_reset;
        test_full_write;
        test_byte_write;
        test_collision;
        test_back_to_back;
        test_reset_mid_run;
        test_reset_mid_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
